divisible_by_n_stream: RTL and testbench

- Serial divisibility checker, generalised successor of the fixed divide-by-3 checker.
- Consumes one bit per valid cycle and reports whether the number accumulated so far is divisible by a parametrised DIVISOR.
- Tracks only the running remainder in a bounded FSM, never the full value, so stream length is unlimited.
- Sits in the bit-serial datapath beside the other stream monitors; adds qualified input, explicit per-number clear, and remainder visibility.

---
 rtl/divisible_by_n_stream.sv | 123 ++++++++++++
 tb/tb_divisible_by_n_stream.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/divisible_by_n_stream.sv
// Serial divisibility checker: reports whether the bits accepted so far form a value divisible by DIVISOR.
// Latency: one cycle. The outputs update on the same edge that accepts a bit.
// Backpressure: none. The block accepts a bit on every cycle with din_valid=1. A cycle with din_valid=0 holds all state.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset. Assertion is asynchronous; release is expected to be synchronous.
//   din        serial data bit, sampled only when din_valid=1
//   din_valid  qualifier for din
//   clear      starts a new number. When din_valid is also 1, din becomes bit 0 of the new number.
//   dout       1 when the accumulated value mod DIVISOR == 0. Gate this output with dout_valid.
//   dout_valid 1 once at least one bit of the current number has been accepted
//   rem        running remainder (accumulated value mod DIVISOR)
//
// Build option: when DIV_LSB_FIRST_EN is defined, the stream is LSB-first and a weight register
// tracks 2^k mod DIVISOR. When it is not defined, the stream is MSB-first and there is no weight register.

module divisible_by_n_stream #(
  parameter  int DIVISOR = 3,
  // The clamp only keeps the widths legal while the elaboration error below is being reported.
  localparam int REM_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             dout,
  output logic             dout_valid,
  output logic [REM_W-1:0] rem
);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("divisible_by_n_stream: DIVISOR must be >= 2");
  end

  // The divisor is widened by one bit. Every pre-reduction sum is below 2*DIVISOR,
  // so that sum fits in REM_W+1 bits.
  localparam logic [REM_W:0] DIV_X = (REM_W+1)'(DIVISOR);

  logic [REM_W-1:0] rem_q;
  logic             dout_q;
  logic             dout_valid_q;
  logic [REM_W-1:0] rem_nxt;

  // A clear in the same cycle as a bit discards the old remainder before the update.
  // The shared update path therefore yields r' = din for the first bit of the new number.
  logic [REM_W-1:0] rem_base;
  assign rem_base = clear ? '0 : rem_q;

`ifdef DIV_LSB_FIRST_EN

  localparam logic [REM_W-1:0] W_ONE = REM_W'(1);

  logic [REM_W-1:0] w_q;
  logic [REM_W-1:0] w_base;
  logic [REM_W-1:0] w_nxt;
  logic [REM_W:0]   lsb_sum;
  logic [REM_W:0]   lsb_red;
  logic [REM_W:0]   w_dbl;
  logic [REM_W:0]   w_red;

  // A clear restarts the weight at 2^0.
  // On clear plus a valid bit, the weight stored for the next bit becomes 2 mod D.
  assign w_base  = clear ? W_ONE : w_q;

  // r' = (r + din*w) mod D.
  // Both operands are below D, so one conditional subtract is enough.
  assign lsb_sum = {1'b0, rem_base} + (din ? {1'b0, w_base} : '0);
  assign lsb_red = (lsb_sum >= DIV_X) ? (lsb_sum - DIV_X) : lsb_sum;
  assign rem_nxt = lsb_red[REM_W-1:0];

  // w' = (2*w) mod D.
  // The value 2*w is below 2D, so one conditional subtract is enough.
  assign w_dbl   = {w_base, 1'b0};
  assign w_red   = (w_dbl >= DIV_X) ? (w_dbl - DIV_X) : w_dbl;
  assign w_nxt   = w_red[REM_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_q <= W_ONE;
    end else if (din_valid) begin
      w_q <= w_nxt;
    end else if (clear) begin
      w_q <= W_ONE;
    end
  end

`else

  logic [REM_W:0] msb_sum;
  logic [REM_W:0] msb_red;

  // r' = (2*r + din) mod D.
  // The value {r, din} is exactly 2*r + din, and it is below 2D.
  assign msb_sum = {rem_base, din};
  assign msb_red = (msb_sum >= DIV_X) ? (msb_sum - DIV_X) : msb_sum;
  assign rem_nxt = msb_red[REM_W-1:0];

`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else if (din_valid) begin
      rem_q        <= rem_nxt;
      dout_q       <= (rem_nxt == '0);
      dout_valid_q <= 1'b1;
    end else if (clear) begin
      // After a clear the number is empty, so no result is reported until the next bit arrives.
      rem_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end
  end

  assign rem        = rem_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_divisible_by_n_stream.sv
module tb_divisible_by_n_stream;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Instances: 0 is D=3, 1 is D=5, 2 is D=7, 3 is D=4 (a power of two).
  int dv [4] = '{3, 5, 7, 4};

  logic       din_x  [4];
  logic       vld_x  [4];
  logic       clr_x  [4];
  logic       dout_x [4];
  logic       ov_x   [4];
  logic [2:0] rem_x  [4];

  logic [1:0] rem0;
  logic [2:0] rem1;
  logic [2:0] rem2;
  logic [1:0] rem3;
  assign rem_x[0] = {1'b0, rem0};
  assign rem_x[1] = rem1;
  assign rem_x[2] = rem2;
  assign rem_x[3] = {1'b0, rem3};

  divisible_by_n_stream #(.DIVISOR(3)) u_d3 (
    .clk(clk), .resetn(resetn), .din(din_x[0]), .din_valid(vld_x[0]), .clear(clr_x[0]),
    .dout(dout_x[0]), .dout_valid(ov_x[0]), .rem(rem0));
  divisible_by_n_stream #(.DIVISOR(5)) u_d5 (
    .clk(clk), .resetn(resetn), .din(din_x[1]), .din_valid(vld_x[1]), .clear(clr_x[1]),
    .dout(dout_x[1]), .dout_valid(ov_x[1]), .rem(rem1));
  divisible_by_n_stream #(.DIVISOR(7)) u_d7 (
    .clk(clk), .resetn(resetn), .din(din_x[2]), .din_valid(vld_x[2]), .clear(clr_x[2]),
    .dout(dout_x[2]), .dout_valid(ov_x[2]), .rem(rem2));
  divisible_by_n_stream #(.DIVISOR(4)) u_d4 (
    .clk(clk), .resetn(resetn), .din(din_x[3]), .din_valid(vld_x[3]), .clear(clr_x[3]),
    .dout(dout_x[3]), .dout_valid(ov_x[3]), .rem(rem3));

  typedef struct {
    int inst;
    int r;
    bit d;
    bit v;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      din_x[i] = 1'b0;
      vld_x[i] = 1'b0;
      clr_x[i] = 1'b0;
    end
  endtask

  // Drive one cycle on one instance and queue the outputs expected after the next edge.
  task automatic step(input int inst, input bit v, input bit d, input bit c,
                      input int er, input bit ed, input bit ev);
    exp_t e;
    @(negedge clk);
    idle_all();
    vld_x[inst] = v;
    din_x[inst] = d;
    clr_x[inst] = c;
    e.inst = inst;
    e.r = er;
    e.d = ed;
    e.v = ev;
    sbq.push_back(e);
  endtask

  task automatic check_zero(input string tag, input int inst);
    checks++;
    if (rem_x[inst] !== 3'd0 || dout_x[inst] !== 1'b0 || ov_x[inst] !== 1'b0) begin
      failures++;
      $display("FAIL %s inst%0d got rem=%0d dout=%b vld=%b need 0/0/0",
               tag, inst, rem_x[inst], dout_x[inst], ov_x[inst]);
    end
  endtask

  // The monitor compares every queued cycle just after the edge that consumed it.
  // It also checks the remainder bound on every instance.
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (int'(rem_x[i]) >= dv[i]) begin
          failures++;
          $display("FAIL rem_bound inst%0d got rem=%0d need < %0d", i, rem_x[i], dv[i]);
        end
      end
    end
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (rem_x[e.inst] !== 3'(e.r) || dout_x[e.inst] !== e.d || ov_x[e.inst] !== e.v) begin
        failures++;
        $display("FAIL sb inst%0d got rem=%0d dout=%b vld=%b need rem=%0d dout=%b vld=%b",
                 e.inst, rem_x[e.inst], dout_x[e.inst], ov_x[e.inst], e.r, e.d, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    #12;
    for (int i = 0; i < 4; i++) check_zero("reset_state", i);
    @(negedge clk);
    resetn = 1'b1;

`ifdef DIV_LSB_FIRST_EN
    // D=3, LSB-first: the bits 0,1,1 form the value 6. A following bit 1 makes the value 14.
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 2, 0, 1);
    step(0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 1, 0, 2, 0, 1);
    // A clear together with din=1 gives value 1. The next bit then has weight 2, so the value becomes 3.
    step(0, 1, 1, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    // D=5, LSB-first: the bits 1,0,1 form the value 5, followed by a clear alone.
    step(1, 1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 1, 1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 0, 0);
    // D=4, LSB-first: the bits 0,0,1,1 form the value 12. The weight wraps to 0.
    step(3, 1, 0, 0, 0, 1, 1);
    step(3, 1, 0, 0, 0, 1, 1);
    step(3, 1, 1, 0, 0, 1, 1);
    step(3, 1, 1, 0, 0, 1, 1);
`else
    // D=3: the bits 1,1,0 form the value 6.
    step(0, 1, 1, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1, 1);
    // D=3: the bits 1,0,1,1 form the value 11, with two idle cycles between bits.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 2, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 1, 1, 0, 2, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 1, 1, 0, 2, 0, 1);
    // D=3: the bits 1,0 leave rem=2. A clear with a valid bit then starts a new number.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 1);
    step(0, 1, 0, 0, 2, 0, 1);
    step(0, 1, 1, 1, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1, 1);
    // D=5: the bits 1,0,1,0 form the value 10. A clear alone follows, then an idle cycle.
    step(1, 1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 2, 0, 1);
    step(1, 1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // D=4: the bits 1,1,0,0 form the value 12.
    step(3, 1, 1, 0, 1, 0, 1);
    step(3, 1, 1, 0, 3, 0, 1);
    step(3, 1, 0, 0, 2, 0, 1);
    step(3, 1, 0, 0, 0, 1, 1);
`endif
    // D=4: a clear followed by a stream of zeros is divisible from the first bit.
    step(3, 0, 0, 1, 0, 0, 0);
    step(3, 1, 0, 0, 0, 1, 1);
    step(3, 1, 0, 0, 0, 1, 1);

    // D=7: two bits, then a reset pulse mid-cycle, then bits 1,1,1 (the value 7 in either bit order).
    step(2, 1, 1, 0, 1, 0, 1);
`ifdef DIV_LSB_FIRST_EN
    step(2, 1, 1, 0, 3, 0, 1);
`else
    step(2, 1, 1, 0, 3, 0, 1);
`endif
    @(posedge clk);
    #2;
    idle_all();
    resetn = 1'b0;
    #1;
    check_zero("async_reset", 2);
    #1;
    resetn = 1'b1;
    step(2, 1, 1, 0, 1, 0, 1);
    step(2, 1, 1, 0, 3, 0, 1);
    step(2, 1, 1, 0, 0, 1, 1);
    step(2, 0, 0, 0, 0, 1, 1);

    // Allow a bounded number of cycles for the monitor to drain the queue.
    for (int n = 0; n < 10 && sbq.size() > 0; n++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending need 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
